// File: rtl/cal1d_fp16_pool_sum_ctrl.sv
// Pooling-sum controller: folds each window of cfg_kernel_width fp17 vectors
// through an external adder array, one add in flight, then emits the window sum.
module cal1d_fp16_pool_sum_ctrl #(
    parameter int LANES = 4,
    parameter int KW    = 3
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rst,
    input  logic [KW-1:0]         cfg_kernel_width,
    input  logic                  in_pvld,
    output logic                  in_prdy,
    input  logic [17*LANES-1:0]   in_data,
    output logic                  sum_in_pvld,
    input  logic                  sum_in_prdy,
    output logic [17*LANES-1:0]   sum_a,
    output logic [17*LANES-1:0]   sum_b,
    input  logic                  sum_out_pvld,
    output logic                  sum_out_prdy,
    input  logic [17*LANES-1:0]   sum_z,
    output logic                  out_pvld,
    input  logic                  out_prdy,
    output logic [17*LANES-1:0]   out_data
);
    localparam int DW = 17 * LANES;

    // Every handshake transfers on a rising edge where valid and ready are both high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2,
        OUT  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]   kw_lat_q, kw_lat_d;
    logic [KW-1:0]   cnt_inc;
    logic [KW-1:0]   kw_req;
    logic [DW-1:0]   psum_q, psum_d;

    assign cnt_inc  = cnt_q + KW'(1);
    assign kw_req   = (cfg_kernel_width == '0) ? KW'(1) : cfg_kernel_width;
    assign sum_a    = in_data;
    assign sum_b    = psum_q;
    assign out_data = psum_q;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            kw_lat_q <= KW'(1);
            psum_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            kw_lat_q <= kw_lat_d;
            psum_q   <= psum_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        kw_lat_d     = kw_lat_q;
        psum_d       = psum_q;
        in_prdy      = 1'b0;
        sum_in_pvld  = 1'b0;
        sum_out_prdy = 1'b0;
        out_pvld     = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_prdy = 1'b1;
                if (in_pvld) begin
                    psum_d   = in_data;
                    cnt_d    = KW'(1);
                    kw_lat_d = kw_req;
                    state_d  = (kw_req == KW'(1)) ? OUT : SEND;
                end
            end
            SEND: begin
                // Operand handshake is a straight pass-through; psum is frozen here.
                sum_in_pvld = in_pvld;
                in_prdy     = sum_in_prdy;
                if (in_pvld && sum_in_prdy) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                sum_out_prdy = 1'b1;
                if (sum_out_pvld) begin
                    psum_d  = sum_z;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == kw_lat_q) ? OUT : SEND;
                end
            end
            OUT: begin
                out_pvld = 1'b1;
                if (out_prdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
